mc_control_unit: RTL and testbench
==================================

// Module: mc_control_unit
// PURPOSE
//  Multicycle control FSM for the 16-bit TSC datapath. Decodes the latched IR, sequences IF/ID/EX/MEM/WB,
//  drives alu opcode/funcode plus all datapath mux selects and write strobes. Consumes the ALU's bcond
//  for branches. Sits between the IR/memory interface and the datapath; it is the initiator the ALU answers.
// PARAMETERS
//  WORD_SIZE  16  instruction/data width (from macro.v `WORD_SIZE)
// PORTS
//  clk            in   1   rising-edge clock
//  reset_n        in   1   synchronous, active-low reset
//  instr          in   16  IR contents (opcode=[15:12], funcode=[5:0])
//  bcond          in   1   branch condition from ALU
//  mem_ready      in   1   memory access complete (read data valid / write accepted)
//  alu_opcode     out  4   opcode to ALU;  alu_funcode out 6 funcode to ALU
//  alu_src_a      out  1   0=PC 1=reg A;   alu_src_b out 2  0=reg B 1=sign-ext imm 2=const 1
//  pc_write       out  1   unconditional PC load;  pc_write_cond out 1  PC load iff bcond
//  pc_source      out  2   0=ALU result 1=branch target (PC+imm) 2=jump {PC[15:12],instr[11:0]} 3=reg A
//  ir_write       out  1   latch memory data into IR
//  i_or_d         out  1   0=address from PC 1=from ALU out
//  mem_read/mem_write out 1 each  memory strobes
//  reg_write      out  1   register file write enable
//  reg_dst        out  2   0=rd instr[7:6] 1=rt instr[9:8] 2=$2
//  mem_to_reg     out  2   0=ALU out 1=MDR 2=PC
//  wwd_valid      out  1   one-cycle pulse: output_port <= reg A
//  is_halted      out  1   sticky halt flag
//  num_inst       out  16  fetched-instruction count
// BEHAVIOUR
//  - States: IF, ID, EX, MEM, WB, HALT (registered, Moore outputs). All strobes 0 outside listed states.
//  - Reset: reset_n sampled low at edge -> state=IF, is_halted=0, num_inst=0. While reset_n low, every
//    strobe (pc_write*, ir_write, mem_*, reg_write, wwd_valid) forced 0. Reset mid-MEM aborts the access.
//  - IF: mem_read=1, i_or_d=0. Hold until mem_ready; on mem_ready cycle ir_write=1, next=ID.
//  - ID: alu_opcode=4, alu_src_a=0, alu_src_b=2, pc_source=0, pc_write=1 (PC<=PC+1). num_inst+1.
//    Next: HLT (op15/fn29) -> HALT; defined opcode -> EX; undefined opcode (11-14, or op15 undefined fn) -> IF.
//  - EX, alu_opcode=instr[15:12], alu_funcode=instr[5:0], alu_src_a=1:
//    R-ALU fn0-7 -> src_b=0, next WB.  ADI/ORI/LHI (4,5,6) -> src_b=1, next WB.
//    LWD/SWD (7,8) -> src_b=1, next MEM.
//    BNE/BEQ/BGZ/BLZ (0-3) -> src_b=0, pc_write_cond=1, pc_source=1, next IF (bcond gates load).
//    JMP (9) -> pc_write=1, pc_source=2, next IF.  JAL (10) -> same + reg_write, reg_dst=2, mem_to_reg=2.
//    JPR (fn25) -> pc_write=1, pc_source=3.  JRL (fn26) -> same + reg_write $2 <= PC. Both next IF.
//    WWD (fn28) -> wwd_valid=1 for exactly this cycle, next IF.
//  - MEM: i_or_d=1; LWD mem_read=1, SWD mem_write=1; hold until mem_ready; then LWD->WB, SWD->IF.
//    Strobe stays asserted every wait cycle; exactly one MEM exit per access.
//  - WB: reg_write=1; R-type reg_dst=0, mem_to_reg=0; I-ALU reg_dst=1, mem_to_reg=0; LWD reg_dst=1,
//    mem_to_reg=1. next IF.
//  - HALT: is_halted=1, no strobes, absorbing until reset. num_inst frozen.
//  - num_inst wraps 0xFFFF -> 0x0000. PC updated only via listed pc_write/pc_write_cond cycles.
//  - CPI: R/I-ALU 4+waits, LWD 5, SWD 4, branch/jump/WWD 3, HLT 2 (IF,ID) with mem_ready=1.
// CONFIGURATION
//  MC_CTRL_INST_COUNT_EN defined: num_inst counter as above.
//  Not defined: num_inst tied to 16'h0000, counter register not instantiated.
// TESTING
//  1 reset_n=0 two cycles, mem_ready=1 -> all strobes 0, state IF, num_inst=0, is_halted=0.
//  2 instr=16'hF1C0 (ADD $3,$0,$1), mem_ready=1 -> IF,ID,EX(op=15,fn=0),WB reg_write rd=3; 4 cycles.
//  3 instr=16'h7480 LWD, mem_ready low 3 cycles in MEM -> mem_read held 4 cycles, then WB mem_to_reg=1.
//  4 instr=16'h1004 BEQ with bcond=0 then bcond=1 -> pc_write_cond=1 in EX both times, pc_source=1, 3 cycles.
//  5 instr=16'hA123 JAL -> EX pc_write=1, pc_source=2, reg_write, reg_dst=2, mem_to_reg=2.
//  6 instr=16'hF01D HLT -> is_halted=1 after ID, held 10 cycles; reset_n=0 one cycle -> IF, is_halted=0.

Source files
------------

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle IF/ID/EX/MEM/WB control FSM for the 16-bit TSC datapath.
// Define MC_CTRL_INST_COUNT_EN to build the fetched-instruction counter behind num_inst.
module mc_control_unit #(
   parameter int WORD_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WORD_SIZE-1:0] instr,
   input  logic                 bcond,
   input  logic                 mem_ready,
   output logic [3:0]           alu_opcode,
   output logic [5:0]           alu_funcode,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic                 pc_write,
   output logic                 pc_write_cond,
   output logic [1:0]           pc_source,
   output logic                 ir_write,
   output logic                 i_or_d,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 reg_write,
   output logic [1:0]           reg_dst,
   output logic [1:0]           mem_to_reg,
   output logic                 wwd_valid,
   output logic                 is_halted,
   output logic [WORD_SIZE-1:0] num_inst,
   output logic [2:0]           state_dbg_o
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      C_RALU, C_IALU, C_LWD, C_SWD, C_BR, C_JMP, C_JAL,
      C_JPR, C_JRL, C_WWD, C_HLT, C_UNDEF
   } iclass_e;

   state_e     state_q, state_d;
   iclass_e    iclass;
   logic [3:0] opcode;
   logic [5:0] funcode;
   logic       unused_inputs;

   assign opcode  = instr[15:12];
   assign funcode = instr[5:0];
   // Register fields are steered by the datapath; bcond gates the PC load there, not here.
   assign unused_inputs = ^{instr[11:6], bcond};

   // IR only changes in IF, so the class stays valid for ID through WB.
   always_comb begin
      iclass = C_UNDEF;
      case (opcode)
         4'd0, 4'd1, 4'd2, 4'd3: iclass = C_BR;
         4'd4, 4'd5, 4'd6:       iclass = C_IALU;
         4'd7:                   iclass = C_LWD;
         4'd8:                   iclass = C_SWD;
         4'd9:                   iclass = C_JMP;
         4'd10:                  iclass = C_JAL;
         4'd15: begin
            if (funcode <= 6'd7) begin
               iclass = C_RALU;
            end else begin
               case (funcode)
                  6'd25:   iclass = C_JPR;
                  6'd26:   iclass = C_JRL;
                  6'd28:   iclass = C_WWD;
                  6'd29:   iclass = C_HLT;
                  default: iclass = C_UNDEF;
               endcase
            end
         end
         default: iclass = C_UNDEF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= S_IF;
      else          state_q <= state_d;
   end

   // mem_ready handshake: a request (mem_read/mem_write) is held high every cycle of IF/MEM;
   // the cycle in which mem_ready is high completes it and the FSM leaves on that edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IF: begin
            if (mem_ready) state_d = S_ID;
         end
         S_ID: begin
            if (iclass == C_HLT)        state_d = S_HALT;
            else if (iclass == C_UNDEF) state_d = S_IF;
            else                        state_d = S_EX;
         end
         S_EX: begin
            case (iclass)
               C_RALU, C_IALU: state_d = S_WB;
               C_LWD, C_SWD:   state_d = S_MEM;
               default:        state_d = S_IF;
            endcase
         end
         S_MEM: begin
            if (mem_ready) state_d = (iclass == C_LWD) ? S_WB : S_IF;
         end
         S_WB:    state_d = S_IF;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IF;
      endcase
   end

   always_comb begin
      alu_opcode    = 4'd0;
      alu_funcode   = 6'd0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'd0;
      ir_write      = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 2'd0;
      mem_to_reg    = 2'd0;
      wwd_valid     = 1'b0;
      case (state_q)
         S_IF: begin
            mem_read = 1'b1;
            ir_write = mem_ready;
         end
         S_ID: begin
            alu_opcode = 4'd4;
            alu_src_b  = 2'd2;
            pc_write   = 1'b1;
         end
         S_EX: begin
            alu_opcode  = opcode;
            alu_funcode = funcode;
            alu_src_a   = 1'b1;
            case (iclass)
               C_IALU, C_LWD, C_SWD: alu_src_b = 2'd1;
               C_BR: begin
                  pc_write_cond = 1'b1;
                  pc_source     = 2'd1;
               end
               C_JMP: begin
                  pc_write  = 1'b1;
                  pc_source = 2'd2;
               end
               C_JAL: begin
                  pc_write   = 1'b1;
                  pc_source  = 2'd2;
                  reg_write  = 1'b1;
                  reg_dst    = 2'd2;
                  mem_to_reg = 2'd2;
               end
               C_JPR: begin
                  pc_write  = 1'b1;
                  pc_source = 2'd3;
               end
               C_JRL: begin
                  pc_write   = 1'b1;
                  pc_source  = 2'd3;
                  reg_write  = 1'b1;
                  reg_dst    = 2'd2;
                  mem_to_reg = 2'd2;
               end
               C_WWD:   wwd_valid = 1'b1;
               default: ;
            endcase
         end
         S_MEM: begin
            i_or_d    = 1'b1;
            mem_read  = (iclass == C_LWD);
            mem_write = (iclass == C_SWD);
         end
         S_WB: begin
            reg_write = 1'b1;
            if (iclass == C_LWD) begin
               reg_dst    = 2'd1;
               mem_to_reg = 2'd1;
            end else if (iclass == C_IALU) begin
               reg_dst = 2'd1;
            end
         end
         default: ;
      endcase
      // Reset aborts any access in flight: no strobe may reach the datapath while reset_n is low.
      if (!reset_n) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         ir_write      = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         reg_write     = 1'b0;
         wwd_valid     = 1'b0;
      end
   end

   assign is_halted   = (state_q == S_HALT);
   assign state_dbg_o = state_q;

`ifdef MC_CTRL_INST_COUNT_EN
   logic [WORD_SIZE-1:0] num_inst_q, num_inst_d;

   always_comb begin
      num_inst_d = num_inst_q;
      if (state_q == S_ID) num_inst_d = num_inst_q + WORD_SIZE'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) num_inst_q <= '0;
      else          num_inst_q <= num_inst_d;
   end

   assign num_inst = num_inst_q;
`else
   assign num_inst = '0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed per-cycle checks of the mc_control_unit state/strobe sequences.
module tb_mc_control_unit;

  localparam logic [2:0] ST_IF   = 3'd0;
  localparam logic [2:0] ST_ID   = 3'd1;
  localparam logic [2:0] ST_EX   = 3'd2;
  localparam logic [2:0] ST_MEM  = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;
  localparam logic [2:0] ST_HALT = 3'd5;

  typedef struct packed {
    logic [3:0]  op;
    logic [5:0]  fn;
    logic        sa;
    logic [1:0]  sb;
    logic        pw;
    logic        pwc;
    logic [1:0]  ps;
    logic        irw;
    logic        iod;
    logic        mr;
    logic        mw;
    logic        rw;
    logic [1:0]  rd;
    logic [1:0]  m2r;
    logic        wwd;
    logic        halt;
    logic [2:0]  st;
    logic [15:0] num;
  } ctl_t;

  typedef struct packed {
    logic        rst_n;
    logic        rdy;
    logic        bc;
    logic [15:0] ins;
    ctl_t        e;
  } step_t;

  logic        clk;
  logic        reset_n;
  logic [15:0] instr;
  logic        bcond;
  logic        mem_ready;
  logic [3:0]  alu_opcode;
  logic [5:0]  alu_funcode;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  pc_source;
  logic        ir_write;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic        wwd_valid;
  logic        is_halted;
  logic [15:0] num_inst;
  logic [2:0]  state_dbg_o;

  int          n_chk;
  int          n_pass;
  logic [15:0] cnt;
  step_t       sq[$];

  mc_control_unit dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .bcond(bcond), .mem_ready(mem_ready),
    .alu_opcode(alu_opcode), .alu_funcode(alu_funcode), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .wwd_valid(wwd_valid), .is_halted(is_halted), .num_inst(num_inst), .state_dbg_o(state_dbg_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t sample();
    ctl_t c;
    c.op = alu_opcode;   c.fn = alu_funcode;  c.sa = alu_src_a;   c.sb = alu_src_b;
    c.pw = pc_write;     c.pwc = pc_write_cond; c.ps = pc_source; c.irw = ir_write;
    c.iod = i_or_d;      c.mr = mem_read;     c.mw = mem_write;   c.rw = reg_write;
    c.rd = reg_dst;      c.m2r = mem_to_reg;  c.wwd = wwd_valid;  c.halt = is_halted;
    c.st = state_dbg_o;  c.num = num_inst;
    return c;
  endfunction

  function automatic ctl_t mk(input logic [2:0] st);
    ctl_t c;
    c = '0;
    c.st = st;
    return c;
  endfunction

  function automatic ctl_t f_if(input logic rdy);
    ctl_t c;
    c = mk(ST_IF);
    c.mr = 1'b1;
    c.irw = rdy;
    return c;
  endfunction

  function automatic ctl_t f_id();
    ctl_t c;
    c = mk(ST_ID);
    c.op = 4'd4;
    c.sb = 2'd2;
    c.pw = 1'b1;
    return c;
  endfunction

  function automatic ctl_t f_ex(input logic [15:0] ins);
    ctl_t c;
    c = mk(ST_EX);
    c.op = ins[15:12];
    c.fn = ins[5:0];
    c.sa = 1'b1;
    return c;
  endfunction

  function automatic logic [15:0] exp_num();
`ifdef MC_CTRL_INST_COUNT_EN
    return cnt;
`else
    return 16'h0000;
`endif
  endfunction

  // driver tasks
  task automatic add(input logic rst_n, input logic rdy, input logic bc,
                     input logic [15:0] ins, input ctl_t e);
    step_t s;
    s.rst_n = rst_n; s.rdy = rdy; s.bc = bc; s.ins = ins; s.e = e;
    sq.push_back(s);
  endtask

  task automatic adv(input logic rst_n, input logic [2:0] st);
    @(posedge clk);
    if (!rst_n) cnt = 16'h0000;
    else if (st == ST_ID) cnt = cnt + 16'h0001;
    #1;
  endtask

  task automatic test_reset();
    ctl_t e, got;
    sq.delete();
    add(1'b0, 1'b1, 1'b0, 16'hF1C0, mk(ST_IF));
    add(1'b0, 1'b1, 1'b0, 16'hF1C0, mk(ST_IF));
    add(1'b1, 1'b1, 1'b0, 16'hF1C0, f_if(1'b1));
    add(1'b1, 1'b1, 1'b0, 16'hF1C0, f_id());
    add(1'b1, 1'b1, 1'b0, 16'hF1C0, f_ex(16'hF1C0));
    e = mk(ST_WB); e.rw = 1'b1;
    add(1'b1, 1'b1, 1'b0, 16'hF1C0, e);
    foreach (sq[i]) begin
      reset_n = sq[i].rst_n; mem_ready = sq[i].rdy; bcond = sq[i].bc; instr = sq[i].ins;
      #1;
      e = sq[i].e; e.num = exp_num();
      got = sample();
      n_chk++;
      if (got !== e) $display("FAIL reset step %0d: got %h, required %h", i, got, e);
      else n_pass++;
      adv(sq[i].rst_n, e.st);
    end
  endtask

  task automatic test_alu();
    ctl_t e, got;
    sq.delete();
    add(1'b1, 1'b1, 1'b0, 16'hF1C0, f_if(1'b1));
    add(1'b1, 1'b1, 1'b0, 16'hF1C0, f_id());
    add(1'b1, 1'b1, 1'b0, 16'hF1C0, f_ex(16'hF1C0));
    e = mk(ST_WB); e.rw = 1'b1;
    add(1'b1, 1'b1, 1'b0, 16'hF1C0, e);
    add(1'b1, 1'b0, 1'b0, 16'h5203, f_if(1'b0));
    add(1'b1, 1'b1, 1'b0, 16'h5203, f_if(1'b1));
    add(1'b1, 1'b1, 1'b0, 16'h5203, f_id());
    e = f_ex(16'h5203); e.sb = 2'd1;
    add(1'b1, 1'b1, 1'b0, 16'h5203, e);
    e = mk(ST_WB); e.rw = 1'b1; e.rd = 2'd1;
    add(1'b1, 1'b1, 1'b0, 16'h5203, e);
    foreach (sq[i]) begin
      reset_n = sq[i].rst_n; mem_ready = sq[i].rdy; bcond = sq[i].bc; instr = sq[i].ins;
      #1;
      e = sq[i].e; e.num = exp_num();
      got = sample();
      n_chk++;
      if (got !== e) $display("FAIL alu step %0d: got %h, required %h", i, got, e);
      else n_pass++;
      adv(sq[i].rst_n, e.st);
    end
  endtask

  task automatic test_mem();
    ctl_t e, got;
    sq.delete();
    add(1'b1, 1'b1, 1'b0, 16'h7480, f_if(1'b1));
    add(1'b1, 1'b1, 1'b0, 16'h7480, f_id());
    e = f_ex(16'h7480); e.sb = 2'd1;
    add(1'b1, 1'b1, 1'b0, 16'h7480, e);
    e = mk(ST_MEM); e.iod = 1'b1; e.mr = 1'b1;
    add(1'b1, 1'b0, 1'b0, 16'h7480, e);
    add(1'b1, 1'b0, 1'b0, 16'h7480, e);
    add(1'b1, 1'b0, 1'b0, 16'h7480, e);
    add(1'b1, 1'b1, 1'b0, 16'h7480, e);
    e = mk(ST_WB); e.rw = 1'b1; e.rd = 2'd1; e.m2r = 2'd1;
    add(1'b1, 1'b1, 1'b0, 16'h7480, e);
    add(1'b1, 1'b1, 1'b0, 16'h8480, f_if(1'b1));
    add(1'b1, 1'b1, 1'b0, 16'h8480, f_id());
    e = f_ex(16'h8480); e.sb = 2'd1;
    add(1'b1, 1'b1, 1'b0, 16'h8480, e);
    e = mk(ST_MEM); e.iod = 1'b1; e.mw = 1'b1;
    add(1'b1, 1'b0, 1'b0, 16'h8480, e);
    add(1'b1, 1'b1, 1'b0, 16'h8480, e);
    foreach (sq[i]) begin
      reset_n = sq[i].rst_n; mem_ready = sq[i].rdy; bcond = sq[i].bc; instr = sq[i].ins;
      #1;
      e = sq[i].e; e.num = exp_num();
      got = sample();
      n_chk++;
      if (got !== e) $display("FAIL mem step %0d: got %h, required %h", i, got, e);
      else n_pass++;
      adv(sq[i].rst_n, e.st);
    end
  endtask

  task automatic test_branch();
    ctl_t e, got;
    logic [15:0] br[3];
    logic        bv[3];
    br[0] = 16'h1004; bv[0] = 1'b0;
    br[1] = 16'h1004; bv[1] = 1'b1;
    br[2] = 16'h3FFF; bv[2] = 1'b1;
    sq.delete();
    for (int k = 0; k < 3; k++) begin
      add(1'b1, 1'b1, bv[k], br[k], f_if(1'b1));
      add(1'b1, 1'b1, bv[k], br[k], f_id());
      e = f_ex(br[k]); e.pwc = 1'b1; e.ps = 2'd1;
      add(1'b1, 1'b1, bv[k], br[k], e);
    end
    foreach (sq[i]) begin
      reset_n = sq[i].rst_n; mem_ready = sq[i].rdy; bcond = sq[i].bc; instr = sq[i].ins;
      #1;
      e = sq[i].e; e.num = exp_num();
      got = sample();
      n_chk++;
      if (got !== e) $display("FAIL branch step %0d: got %h, required %h", i, got, e);
      else n_pass++;
      adv(sq[i].rst_n, e.st);
    end
  endtask

  task automatic test_jump();
    ctl_t e, got;
    sq.delete();
    add(1'b1, 1'b1, 1'b0, 16'h9ABC, f_if(1'b1));
    add(1'b1, 1'b1, 1'b0, 16'h9ABC, f_id());
    e = f_ex(16'h9ABC); e.pw = 1'b1; e.ps = 2'd2;
    add(1'b1, 1'b1, 1'b0, 16'h9ABC, e);
    add(1'b1, 1'b1, 1'b0, 16'hA123, f_if(1'b1));
    add(1'b1, 1'b1, 1'b0, 16'hA123, f_id());
    e = f_ex(16'hA123); e.pw = 1'b1; e.ps = 2'd2; e.rw = 1'b1; e.rd = 2'd2; e.m2r = 2'd2;
    add(1'b1, 1'b1, 1'b0, 16'hA123, e);
    add(1'b1, 1'b1, 1'b0, 16'hF019, f_if(1'b1));
    add(1'b1, 1'b1, 1'b0, 16'hF019, f_id());
    e = f_ex(16'hF019); e.pw = 1'b1; e.ps = 2'd3;
    add(1'b1, 1'b1, 1'b0, 16'hF019, e);
    add(1'b1, 1'b1, 1'b0, 16'hF01A, f_if(1'b1));
    add(1'b1, 1'b1, 1'b0, 16'hF01A, f_id());
    e = f_ex(16'hF01A); e.pw = 1'b1; e.ps = 2'd3; e.rw = 1'b1; e.rd = 2'd2; e.m2r = 2'd2;
    add(1'b1, 1'b1, 1'b0, 16'hF01A, e);
    foreach (sq[i]) begin
      reset_n = sq[i].rst_n; mem_ready = sq[i].rdy; bcond = sq[i].bc; instr = sq[i].ins;
      #1;
      e = sq[i].e; e.num = exp_num();
      got = sample();
      n_chk++;
      if (got !== e) $display("FAIL jump step %0d: got %h, required %h", i, got, e);
      else n_pass++;
      adv(sq[i].rst_n, e.st);
    end
  endtask

  task automatic test_wwd_undef();
    ctl_t e, got;
    sq.delete();
    add(1'b1, 1'b1, 1'b0, 16'hF01C, f_if(1'b1));
    add(1'b1, 1'b1, 1'b0, 16'hF01C, f_id());
    e = f_ex(16'hF01C); e.wwd = 1'b1;
    add(1'b1, 1'b1, 1'b0, 16'hF01C, e);
    add(1'b1, 1'b1, 1'b0, 16'hB000, f_if(1'b1));
    add(1'b1, 1'b1, 1'b0, 16'hB000, f_id());
    add(1'b1, 1'b1, 1'b0, 16'hE123, f_if(1'b1));
    add(1'b1, 1'b1, 1'b0, 16'hE123, f_id());
    add(1'b1, 1'b1, 1'b0, 16'hF01F, f_if(1'b1));
    add(1'b1, 1'b1, 1'b0, 16'hF01F, f_id());
    foreach (sq[i]) begin
      reset_n = sq[i].rst_n; mem_ready = sq[i].rdy; bcond = sq[i].bc; instr = sq[i].ins;
      #1;
      e = sq[i].e; e.num = exp_num();
      got = sample();
      n_chk++;
      if (got !== e) $display("FAIL wwd_undef step %0d: got %h, required %h", i, got, e);
      else n_pass++;
      adv(sq[i].rst_n, e.st);
    end
  endtask

  task automatic test_reset_mid_mem();
    ctl_t e, got;
    sq.delete();
    add(1'b1, 1'b1, 1'b0, 16'h7480, f_if(1'b1));
    add(1'b1, 1'b1, 1'b0, 16'h7480, f_id());
    e = f_ex(16'h7480); e.sb = 2'd1;
    add(1'b1, 1'b1, 1'b0, 16'h7480, e);
    e = mk(ST_MEM); e.iod = 1'b1; e.mr = 1'b1;
    add(1'b1, 1'b0, 1'b0, 16'h7480, e);
    e = mk(ST_MEM); e.iod = 1'b1;
    add(1'b0, 1'b0, 1'b0, 16'h7480, e);
    add(1'b1, 1'b1, 1'b0, 16'h7480, f_if(1'b1));
    add(1'b1, 1'b1, 1'b0, 16'h7480, f_id());
    e = f_ex(16'h7480); e.sb = 2'd1;
    add(1'b1, 1'b1, 1'b0, 16'h7480, e);
    e = mk(ST_MEM); e.iod = 1'b1; e.mr = 1'b1;
    add(1'b1, 1'b1, 1'b0, 16'h7480, e);
    e = mk(ST_WB); e.rw = 1'b1; e.rd = 2'd1; e.m2r = 2'd1;
    add(1'b1, 1'b1, 1'b0, 16'h7480, e);
    foreach (sq[i]) begin
      reset_n = sq[i].rst_n; mem_ready = sq[i].rdy; bcond = sq[i].bc; instr = sq[i].ins;
      #1;
      e = sq[i].e; e.num = exp_num();
      got = sample();
      n_chk++;
      if (got !== e) $display("FAIL reset_mid_mem step %0d: got %h, required %h", i, got, e);
      else n_pass++;
      adv(sq[i].rst_n, e.st);
    end
  endtask

  task automatic test_halt();
    ctl_t e, got;
    sq.delete();
    add(1'b1, 1'b1, 1'b0, 16'hF01D, f_if(1'b1));
    add(1'b1, 1'b1, 1'b0, 16'hF01D, f_id());
    e = mk(ST_HALT); e.halt = 1'b1;
    for (int k = 0; k < 10; k++) add(1'b1, k[0], k[1], 16'hF01D, e);
    add(1'b0, 1'b1, 1'b0, 16'hF01D, e);
    add(1'b1, 1'b1, 1'b0, 16'hF1C0, f_if(1'b1));
    add(1'b1, 1'b1, 1'b0, 16'hF1C0, f_id());
    add(1'b1, 1'b1, 1'b0, 16'hF1C0, f_ex(16'hF1C0));
    e = mk(ST_WB); e.rw = 1'b1;
    add(1'b1, 1'b1, 1'b0, 16'hF1C0, e);
    foreach (sq[i]) begin
      reset_n = sq[i].rst_n; mem_ready = sq[i].rdy; bcond = sq[i].bc; instr = sq[i].ins;
      #1;
      e = sq[i].e; e.num = exp_num();
      got = sample();
      n_chk++;
      if (got !== e) $display("FAIL halt step %0d: got %h, required %h", i, got, e);
      else n_pass++;
      adv(sq[i].rst_n, e.st);
    end
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    cnt       = 16'h0000;
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    bcond     = 1'b0;
    instr     = 16'hF1C0;
    @(posedge clk);
    #1;
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_jump();
    test_wwd_undef();
    test_reset_mid_mem();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
